axi_rd_arbiter: RTL and testbench



---
 rtl/axi_rd_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// 2:1 AXI4 read-channel arbiter: one burst in flight, R routed back to the owner, beat count checked against arlen.
// Build option RD_ARB_DC_PRIO_EN: fixed priority for s1 (D-cache); otherwise round-robin between s0 and s1.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  // requester 0 (I-cache refill)
  input  logic              s0_arvalid,
  output logic              s0_arready,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0]        s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  input  logic [3:0]        s0_arcache,
  input  logic [2:0]        s0_arprot,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  // requester 1 (D-cache refill)
  input  logic              s1_arvalid,
  output logic              s1_arready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0]        s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  input  logic [3:0]        s1_arcache,
  input  logic [2:0]        s1_arprot,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  // memory side
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic [3:0]        m_arcache,
  output logic [2:0]        m_arprot,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  // status
  output logic              grant_id,
  output logic              err_len
);

  // state | meaning
  // IDLE  | no owner; arbitrate among pending requesters
  // ADDR  | owner's AR presented on m; waiting for m_arready
  // DATA  | R beats routed to owner until the rlast handshake
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] len_q;
  logic [7:0] beat_cnt;
  logic       in_addr;
  logic       in_data;
  logic       any_req;
  logic       win;
  logic       r_hs;
  logic       ar_hs;

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);
  assign any_req = s0_arvalid | s1_arvalid;
  assign ar_hs   = in_addr & m_arready;
  assign r_hs    = in_data & m_rvalid & m_rready;

`ifdef RD_ARB_DC_PRIO_EN
  assign win = s1_arvalid;
`else
  // last_q holds the requester served most recently; resets to s1 so s0 wins the first tie.
  logic last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (r_hs && m_rlast) begin
      last_q <= grant_id;
    end
  end

  assign win = (s0_arvalid && s1_arvalid) ? ~last_q : s1_arvalid;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ADDR;
      ADDR:    if (m_arready) state_nxt = DATA;
      DATA:    if (r_hs && m_rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant_id <= 1'b0;
      len_q    <= 8'd0;
      beat_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        grant_id <= win;
      end
      if (ar_hs) begin
        len_q    <= m_arlen;
        beat_cnt <= 8'd0;
      end else if (r_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  // AR channel: payload only leaves the block while in ADDR.
  always_comb begin
    m_arvalid  = in_addr;
    m_araddr   = '0;
    m_arlen    = '0;
    m_arsize   = '0;
    m_arburst  = '0;
    m_arcache  = '0;
    m_arprot   = '0;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    if (in_addr) begin
      if (grant_id) begin
        m_araddr   = s1_araddr;
        m_arlen    = s1_arlen;
        m_arsize   = s1_arsize;
        m_arburst  = s1_arburst;
        m_arcache  = s1_arcache;
        m_arprot   = s1_arprot;
        s1_arready = m_arready;
      end else begin
        m_araddr   = s0_araddr;
        m_arlen    = s0_arlen;
        m_arsize   = s0_arsize;
        m_arburst  = s0_arburst;
        m_arcache  = s0_arcache;
        m_arprot   = s0_arprot;
        s0_arready = m_arready;
      end
    end
  end

  // R channel: the owner sees the memory beat unchanged, the other side sees nothing.
  always_comb begin
    m_rready  = 1'b0;
    s0_rvalid = 1'b0;
    s0_rdata  = '0;
    s0_rresp  = '0;
    s0_rlast  = 1'b0;
    s1_rvalid = 1'b0;
    s1_rdata  = '0;
    s1_rresp  = '0;
    s1_rlast  = 1'b0;
    if (in_data) begin
      if (grant_id) begin
        m_rready  = s1_rready;
        s1_rvalid = m_rvalid;
        s1_rdata  = m_rdata;
        s1_rresp  = m_rresp;
        s1_rlast  = m_rlast;
      end else begin
        m_rready  = s0_rready;
        s0_rvalid = m_rvalid;
        s0_rdata  = m_rdata;
        s0_rresp  = m_rresp;
        s0_rlast  = m_rlast;
      end
    end
  end

  // beat_cnt counts beats already taken, so the final beat of a correct burst sees beat_cnt == arlen.
  always_comb begin
    err_len = 1'b0;
    if (r_hs) begin
      err_len = m_rlast ? (beat_cnt != len_q) : (beat_cnt == len_q);
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: random requesters and memory, reference arbitration/beat model, decoupled monitor.
module tb_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int PW = AW + 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]         s_arvalid;
  logic [1:0]         s_rready;
  logic [1:0][AW-1:0] s_araddr;
  logic [1:0][7:0]    s_arlen;
  logic [1:0][2:0]    s_arsize;
  logic [1:0][1:0]    s_arburst;
  logic [1:0][3:0]    s_arcache;
  logic [1:0][2:0]    s_arprot;
  wire  [1:0]         s_arready;
  wire  [1:0]         s_rvalid;
  wire  [1:0]         s_rlast;
  wire  [1:0][DW-1:0] s_rdata;
  wire  [1:0][1:0]    s_rresp;

  wire          m_arvalid, m_rready, grant_id, err_len;
  wire [AW-1:0] m_araddr;
  wire [7:0]    m_arlen;
  wire [2:0]    m_arsize;
  wire [1:0]    m_arburst;
  wire [3:0]    m_arcache;
  wire [2:0]    m_arprot;
  logic          m_arready, m_rvalid, m_rlast;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(rst),
    .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]), .s0_araddr(s_araddr[0]), .s0_arlen(s_arlen[0]),
    .s0_arsize(s_arsize[0]), .s0_arburst(s_arburst[0]), .s0_arcache(s_arcache[0]), .s0_arprot(s_arprot[0]),
    .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]), .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]),
    .s0_rlast(s_rlast[0]),
    .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]), .s1_araddr(s_araddr[1]), .s1_arlen(s_arlen[1]),
    .s1_arsize(s_arsize[1]), .s1_arburst(s_arburst[1]), .s1_arcache(s_arcache[1]), .s1_arprot(s_arprot[1]),
    .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]), .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]),
    .s1_rlast(s_rlast[1]),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .grant_id(grant_id), .err_len(err_len)
  );

  typedef struct { logic id; logic [PW-1:0] pl; } ar_exp_t;
  typedef struct { logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;
  typedef enum { M_IDLE, M_ADDR, M_DATA } phase_t;

  ar_exp_t exp_ar[$];
  r_exp_t  exp_r[$];
  int      mem_q[$];
  logic    grant_log[$];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state (monitor-owned)
  phase_t mph = M_IDLE;
  logic   last_served = 1'b1;
  logic   own = 1'b0;
  int     cur_len = 0;
  int     mdl_beat = 0;
  int     n_err = 0;
  int     n_beats[2] = '{0, 0};
  ar_exp_t ea;
  r_exp_t  er;

  // handshakes seen at the last negedge, consumed by the drivers after the following posedge
  logic [1:0] hs_s_ar = '0;
  logic       hs_m_ar = 1'b0;
  logic       hs_r = 1'b0;
  logic [7:0] hs_len = '0;

  // stimulus knobs
  int       req_left[2] = '{0, 0};
  int       req_pct = 100, rv_pct = 100, rr_pct = 100, max_len = 7;
  int       force_beats = 0, force_resp = -1;
  logic     mis_en = 1'b0;
  logic     dir_on = 1'b0;
  logic [AW-1:0] dir_addr = '0;
  logic [7:0]    dir_len = '0;
  logic [1:0]    toggle = '0;
  logic     burst_active = 1'b0;
  int       beats_left = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] s_pl(input logic i);
    return {s_araddr[i], s_arlen[i], s_arsize[i], s_arburst[i], s_arcache[i], s_arprot[i]};
  endfunction

  function automatic logic [PW-1:0] m_pl();
    return {m_araddr, m_arlen, m_arsize, m_arburst, m_arcache, m_arprot};
  endfunction

  // Winner among pending requesters: the one not served last wins a tie.
  function automatic logic ref_arb(input logic [1:0] req);
`ifdef RD_ARB_DC_PRIO_EN
    return req[1];
`else
    if (req == 2'b11) return (last_served == 1'b0) ? 1'b1 : 1'b0;
    return req[1];
`endif
  endfunction

  function automatic int plan_beats(input int len);
    if (force_beats > 0) return force_beats;
    if (mis_en && $urandom_range(0, 5) == 0) return int'($urandom_range(1, len + 3));
    return len + 1;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      hs_s_ar = '0; hs_m_ar = 1'b0; hs_r = 1'b0;
      exp_ar.delete(); exp_r.delete();
      mph = M_IDLE; last_served = 1'b1; own = 1'b0; mdl_beat = 0; cur_len = 0;
    end else begin
      hs_s_ar = s_arvalid & s_arready;
      hs_m_ar = m_arvalid & m_arready;
      hs_r    = m_rvalid & m_rready;
      hs_len  = m_arlen;
      if (err_len) n_err++;
      case (mph)
        M_IDLE: begin
          chk("idle_gate", {m_arvalid, m_rready, s_arready, s_rvalid, err_len}, 0);
          if (|s_arvalid) begin
            ea.id = ref_arb(s_arvalid);
            ea.pl = s_pl(ea.id);
            exp_ar.push_back(ea);
            mph = M_ADDR;
          end
        end
        M_ADDR: begin
          ea = exp_ar[0];
          chk("addr_valid", m_arvalid, 1);
          chk("addr_rgate", {m_rready, s_rvalid, err_len}, 0);
          chk("arready_route", s_arready, m_arready ? (2'b01 << ea.id) : 2'b00);
          if (m_arvalid && m_arready) begin
            void'(exp_ar.pop_front());
            chk("grant_id", grant_id, ea.id);
            chk("ar_payload", m_pl(), ea.pl);
            grant_log.push_back(grant_id);
            own = ea.id;
            cur_len = int'(ea.pl[19:12]);
            mdl_beat = 0;
            mph = M_DATA;
          end
        end
        default: begin
          chk("r_route", s_rvalid, m_rvalid ? (2'b01 << own) : 2'b00);
          chk("rready_route", m_rready, s_rready[own]);
          chk("data_argate", {m_arvalid, s_arready}, 0);
          if (m_rvalid && m_rready) begin
            if (exp_r.size() == 0) begin
              chk("r_unexpected_beat", 1, 0);
            end else begin
              er = exp_r.pop_front();
              chk("rdata", s_rdata[own], er.data);
              chk("rresp", s_rresp[own], er.resp);
              chk("rlast", s_rlast[own], er.last);
              chk("err_len", err_len, er.last ? ((mdl_beat % 256) != cur_len) : ((mdl_beat % 256) == cur_len));
              n_beats[own]++;
              mdl_beat++;
              if (er.last) begin
                last_served = own;
                mph = M_IDLE;
              end
            end
          end else begin
            chk("err_quiet", err_len, 0);
          end
        end
      endcase
    end
  end

  // One cycle of requester, memory and rready driving.
  task automatic step();
    r_exp_t b;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (s_arvalid[i] && hs_s_ar[i]) s_arvalid[i] = 1'b0;
      if (!s_arvalid[i] && req_left[i] > 0 && $urandom_range(0, 99) < req_pct) begin
        s_arvalid[i] = 1'b1;
        req_left[i]--;
        s_araddr[i]  = dir_on ? dir_addr : $urandom;
        s_arlen[i]   = dir_on ? dir_len : 8'($urandom_range(0, max_len));
        s_arsize[i]  = 3'($urandom_range(0, 3));
        s_arburst[i] = 2'($urandom_range(0, 2));
        s_arcache[i] = 4'($urandom);
        s_arprot[i]  = 3'($urandom);
      end
    end
    m_arready = ($urandom_range(0, 99) < 70);
    if (hs_m_ar) mem_q.push_back(plan_beats(int'(hs_len)));
    if (m_rvalid && hs_r) begin
      m_rvalid = 1'b0;
      beats_left--;
      if (beats_left == 0) burst_active = 1'b0;
    end
    if (!burst_active && mem_q.size() > 0) begin
      beats_left = mem_q.pop_front();
      burst_active = 1'b1;
    end
    if (burst_active && !m_rvalid && $urandom_range(0, 99) < rv_pct) begin
      m_rvalid = 1'b1;
      m_rdata  = {$urandom, $urandom};
      m_rresp  = (force_resp >= 0) ? 2'(force_resp) : (($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
      m_rlast  = (beats_left == 1);
      b.data = m_rdata; b.resp = m_rresp; b.last = m_rlast;
      exp_r.push_back(b);
    end
    for (int i = 0; i < 2; i++)
      s_rready[i] = toggle[i] ? ~s_rready[i] : ($urandom_range(0, 99) < rr_pct);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_arvalid = '0; s_rready = '0; m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b0;
    burst_active = 1'b0; beats_left = 0; mem_q.delete();
    req_left[0] = 0; req_left[1] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int budget = 4000;
    while (budget > 0 && !(req_left[0] == 0 && req_left[1] == 0 && s_arvalid == 2'b00 &&
                           mph == M_IDLE && !burst_active && mem_q.size() == 0)) begin
      step();
      budget--;
    end
    if (budget == 0) chk({"timeout_", nm}, 0, 1);
  endtask

  task automatic one_burst(input int who, input logic [AW-1:0] addr, input logic [7:0] len, input string nm);
    dir_on = 1'b1; dir_addr = addr; dir_len = len;
    req_left[who] = 1;
    wait_done(nm);
    dir_on = 1'b0;
  endtask

  int e0, b0;
  int budget;
  logic [0:5] exp_order;

  initial begin
    rst = 1'b0;
    s_arvalid = '0; s_rready = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0;
    s_arburst = '0; s_arcache = '0; s_arprot = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0; m_rresp = '0;
    #1 rst = 1'b1;
    #2 chk("reset_outs", {m_arvalid, m_rready, s_arready, s_rvalid, err_len, grant_id}, 0);
    do_reset();

    // s0 alone, 8-beat burst at 0x8000_0000
    e0 = n_err; b0 = n_beats[0];
    one_burst(0, 32'h8000_0000, 8'd7, "t1");
    chk("t1_beats_s0", n_beats[0] - b0, 8);
    chk("t1_err_count", n_err - e0, 0);

    // three rounds of simultaneous requests from a fresh reset
    do_reset();
    grant_log.delete();
    max_len = 3;
    for (int r = 0; r < 3; r++) begin
      req_left[0] = 1; req_left[1] = 1;
      wait_done("t2");
    end
`ifdef RD_ARB_DC_PRIO_EN
    exp_order = 6'b101010;
`else
    exp_order = 6'b010101;
`endif
    chk("t2_grant_count", grant_log.size(), 6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) chk("t2_grant_order", grant_log[k], exp_order[k]);

    // short burst: arlen=3 with rlast on beat 2
    e0 = n_err; force_beats = 2;
    one_burst(0, 32'h0000_1000, 8'd3, "t3a");
    chk("t3a_err_count", n_err - e0, 1);
    // overrun: arlen=1 with rlast on beat 3 (beat 2 overruns, beat 3 ends late)
    e0 = n_err; force_beats = 3;
    one_burst(1, 32'h0000_2000, 8'd1, "t3b");
    chk("t3b_err_count", n_err - e0, 2);
    force_beats = 0;

    // s1 burst with rready toggling every cycle
    rv_pct = 70; toggle = 2'b10; b0 = n_beats[1];
    one_burst(1, 32'h0000_3000, 8'd7, "t4");
    chk("t4_beats_s1", n_beats[1] - b0, 8);
    toggle = 2'b00; rv_pct = 100;

    // reset in the middle of beat 2 of a 4-beat s1 burst
    dir_on = 1'b1; dir_addr = 32'h0000_4000; dir_len = 8'd3; req_left[1] = 1;
    budget = 2000;
    while (budget > 0 && !(mph == M_DATA && mdl_beat == 1 && m_rvalid)) begin step(); budget--; end
    chk("t5_reached_beat2", budget > 0, 1);
    #2 rst = 1'b1;
    #1 chk("t5_async_reset_outs", {m_arvalid, m_rready, s_arready, s_rvalid, err_len, grant_id}, 0);
    do_reset();
    b0 = n_beats[0];
    one_burst(0, 32'h0000_5000, 8'd2, "t5_after");
    chk("t5_beats_s0_after", n_beats[0] - b0, 3);

    // SLVERR on every beat
    force_resp = 2; b0 = n_beats[0];
    one_burst(0, 32'h0000_6000, 8'd5, "t6");
    chk("t6_beats_s0", n_beats[0] - b0, 6);
    force_resp = -1;

    // randomized traffic with occasional beat-count mismatches
    mis_en = 1'b1; max_len = 15; req_pct = 30; rv_pct = 60; rr_pct = 70;
    req_left[0] = 30; req_left[1] = 30;
    wait_done("t7");
    chk("t7_scoreboard_empty", exp_ar.size() + exp_r.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
